alu_op_sequencer: RTL and testbench

- Command-side front end for the 32-bit behavioural ALU.
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a command FIFO.
- Drives each command onto the ALU ports from registers, holds them for a fixed settle time, then captures `r` and the four flags into a tagged result FIFO.
- Results are drained over a second valid/ready handshake.
- Sits between any command source (CPU datapath model, self-test sequencer) and the ALU instance.

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 52 +++++
 rtl/alu_op_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared widths, flag indices, FSM state and record types for the ALU sequencer
package alu_seq_pkg;

  localparam int DATA_W = 32;
  localparam int OPC_W  = 4;
  localparam int TAG_W  = 4;

  localparam int FLAG_ZERO  = 3;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_OVF   = 0;

  localparam int CMD_W = 2 * DATA_W + OPC_W + TAG_W;
  localparam int RES_W = DATA_W + 4 + TAG_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OPC_W-1:0]  aluc;
    logic [TAG_W-1:0]  tag;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [3:0]        flags;
    logic [TAG_W-1:0]  tag;
  } res_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count; push on full is accepted only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage is cleared on reset so the stale head reads as zero afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - buffers ALU commands, drives them onto the ALU for ALU_LAT cycles, queues tagged results
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_aluc,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_r,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_negative,
  input  logic        alu_overflow,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_r,
  output logic [3:0]  res_flags,
  output logic [3:0]  res_tag,
  output logic        busy
);

  localparam int HW  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int CCW = $clog2(CMD_DEPTH) + 1;
  localparam int RCW = $clog2(RES_DEPTH) + 1;

  seq_state_e       state;
  logic [HW-1:0]    hold_cnt;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] cur_tag;

  cmd_t             cmd_din;
  cmd_t             cmd_dout;
  res_t             res_din;
  res_t             res_dout;
  logic             cmd_full, cmd_empty, res_full, res_empty;
  logic [CCW-1:0]   cmd_count;
  logic [RCW-1:0]   res_count;
  logic             cmd_push, res_pop, capture, issue;
  logic [3:0]       alu_flags;

  assign cmd_ready = !cmd_full;
  assign cmd_push  = cmd_valid && cmd_ready;
  assign res_valid = !res_empty;
  assign res_pop   = res_valid && res_ready;
  assign capture   = (state == DRIVE) && (hold_cnt == HW'(ALU_LAT - 1));
  assign busy      = (cmd_count != '0) || !res_empty || (state == DRIVE);

  // Back-to-back issue must leave room for the result captured on the same edge
  always_comb begin
    issue = 1'b0;
    if (state == IDLE)
      issue = !cmd_empty && !res_full;
    else if (capture)
      issue = !cmd_empty && (res_count < RCW'(RES_DEPTH - 1));
  end

  always_comb begin
    alu_flags             = '0;
    alu_flags[FLAG_ZERO]  = alu_zero;
    alu_flags[FLAG_CARRY] = alu_carry;
    alu_flags[FLAG_NEG]   = alu_negative;
    alu_flags[FLAG_OVF]   = alu_overflow;
  end

  assign cmd_din   = '{a: cmd_a, b: cmd_b, aluc: cmd_aluc, tag: tag};
  assign res_din   = '{r: alu_r, flags: alu_flags, tag: cur_tag};
  assign res_r     = res_dout.r;
  assign res_flags = res_dout.flags;
  assign res_tag   = res_dout.tag;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_push),
    .pop   (issue),
    .din   (cmd_din),
    .dout  (cmd_dout),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  sync_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (res_pop),
    .din   (res_din),
    .dout  (res_dout),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      tag      <= '0;
      cur_tag  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_aluc <= '0;
    end else begin
      if (cmd_push) tag <= tag + 1'b1;
      if (issue) begin
        alu_a    <= cmd_dout.a;
        alu_b    <= cmd_dout.b;
        alu_aluc <= cmd_dout.aluc;
        cur_tag  <= cmd_dout.tag;
        hold_cnt <= '0;
        state    <= DRIVE;
      end else if (capture) begin
        state    <= IDLE;
      end else if (state == DRIVE) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer with a behavioural ALU and scoreboard
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_aluc;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [3:0]  alu_aluc;
  logic        alu_zero, alu_carry, alu_negative, alu_overflow;
  logic        res_valid, res_ready;
  logic [31:0] res_r;
  logic [3:0]  res_flags, res_tag;
  logic        busy;

  logic        cmd_valid3, cmd_ready3;
  logic [31:0] cmd_a3, cmd_b3;
  logic [3:0]  cmd_aluc3;
  logic [31:0] alu_a3, alu_b3, alu_r3;
  logic [3:0]  alu_aluc3;
  logic        alu_zero3, alu_carry3, alu_negative3, alu_overflow3;
  logic        res_valid3, res_ready3;
  logic [31:0] res_r3;
  logic [3:0]  res_flags3, res_tag3;
  logic        busy3;

  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    w = '0;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = b << a[4:0];
      4'd6: r = b >> a[4:0];
      4'd7: r = 32'($signed(b) >>> a[4:0]);
      4'd8: r = {31'b0, $signed(a) < $signed(b)};
      4'd9: r = {31'b0, a < b};
      default: r = ~(a | b);
    endcase
    return {r, r == 32'd0, c, r[31], v};
  endfunction

  assign {alu_r, alu_zero, alu_carry, alu_negative, alu_overflow}      = alu_f(alu_a, alu_b, alu_aluc);
  assign {alu_r3, alu_zero3, alu_carry3, alu_negative3, alu_overflow3} = alu_f(alu_a3, alu_b3, alu_aluc3);

  alu_op_sequencer #(.CMD_DEPTH(4), .RES_DEPTH(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_aluc(cmd_aluc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_r(alu_r),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_r(res_r), .res_flags(res_flags),
    .res_tag(res_tag), .busy(busy)
  );

  alu_op_sequencer #(.CMD_DEPTH(4), .RES_DEPTH(4), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_aluc(cmd_aluc3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_aluc(alu_aluc3), .alu_r(alu_r3),
    .alu_zero(alu_zero3), .alu_carry(alu_carry3), .alu_negative(alu_negative3), .alu_overflow(alu_overflow3),
    .res_valid(res_valid3), .res_ready(res_ready3), .res_r(res_r3), .res_flags(res_flags3),
    .res_tag(res_tag3), .busy(busy3)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycle    = 0;
  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];
  logic [39:0] got3_q[$];
  int          pop_cyc[$];
  logic [3:0]  mtag = '0;
  int          hold_n[4] = '{0, 0, 0, 0};

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] r;
    logic [3:0]  flags;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference: every accepted command yields exactly one result, in order, tagged by acceptance count
  always @(negedge clk) begin
    logic [39:0] e, g;
    cycle++;
    if (rst) begin
      exp_q.delete();
      mtag = '0;
    end else begin
      if (res_valid && res_ready) begin
        g = {res_r, res_flags, res_tag};
        got_q.push_back(g);
        pop_cyc.push_back(cycle);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL res_unexpected: actual %0h required no result", g);
        end else begin
          e = exp_q.pop_front();
          check("res_stream", 64'(g), 64'(e));
        end
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back({alu_f(cmd_a, cmd_b, cmd_aluc), mtag});
        mtag = mtag + 4'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        if (alu_a3 == 32'd100 + 32'(i)) hold_n[i]++;
      if (res_valid3 && res_ready3) got3_q.push_back({res_r3, res_flags3, res_tag3});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int k;
    cmd_a = a;
    cmd_b = b;
    cmd_aluc = op;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin
      tick();
      k++;
    end
    if (!cmd_ready) bound_fail("push_wait");
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    if (busy) bound_fail("wait_idle");
  endtask

  task automatic check_reset_outputs(input string tag_s);
    check({tag_s, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag_s, "_alu_a"},     64'(alu_a),     64'd0);
    check({tag_s, "_alu_b"},     64'(alu_b),     64'd0);
    check({tag_s, "_alu_aluc"},  64'(alu_aluc),  64'd0);
    check({tag_s, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag_s, "_res_r"},     64'(res_r),     64'd0);
    check({tag_s, "_res_flags"}, 64'(res_flags), 64'd0);
    check({tag_s, "_res_tag"},   64'(res_tag),   64'd0);
    check({tag_s, "_busy"},      64'(busy),      64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [35:0] m;
    int          k;

    tbl[0]  = '{32'h0000001f, 32'h0000ffff, 4'd2, 32'h0000001f, 4'b0000};
    tbl[1]  = '{32'hffffffff, 32'h00000001, 4'd0, 32'h00000000, 4'b1100};
    tbl[2]  = '{32'h7fffffff, 32'h00000001, 4'd0, 32'h80000000, 4'b0011};
    tbl[3]  = '{32'h00000000, 32'h00000001, 4'd1, 32'hffffffff, 4'b0110};
    tbl[4]  = '{32'h00000005, 32'h00000005, 4'd1, 32'h00000000, 4'b1000};
    tbl[5]  = '{32'hf0f0f0f0, 32'h0f0f0f0f, 4'd3, 32'hffffffff, 4'b0010};
    tbl[6]  = '{32'h12345678, 32'h12345678, 4'd4, 32'h00000000, 4'b1000};
    tbl[7]  = '{32'h00000004, 32'h00000001, 4'd5, 32'h00000010, 4'b0000};
    tbl[8]  = '{32'h00000004, 32'h80000000, 4'd7, 32'hf8000000, 4'b0010};
    tbl[9]  = '{32'hffffffff, 32'h00000001, 4'd8, 32'h00000001, 4'b0000};
    tbl[10] = '{32'hffffffff, 32'h00000001, 4'd9, 32'h00000000, 4'b1000};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_aluc = '0; res_ready = 1'b0;
    cmd_valid3 = 1'b0; cmd_a3 = '0; cmd_b3 = '0; cmd_aluc3 = '0; res_ready3 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");
    check("reset_busy3", 64'(busy3), 64'd0);

    // Single op latency: accepted at E0, ports at E1, result visible after E2
    res_ready = 1'b1;
    cmd_a = 32'h0000001f; cmd_b = 32'h0000ffff; cmd_aluc = 4'b0010; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("lat_e0_res_valid", 64'(res_valid), 64'd0);
    tick();
    check("lat_e1_alu_a", 64'(alu_a), 64'h1f);
    check("lat_e1_alu_b", 64'(alu_b), 64'hffff);
    check("lat_e1_alu_aluc", 64'(alu_aluc), 64'd2);
    check("lat_e1_res_valid", 64'(res_valid), 64'd0);
    tick();
    m = alu_f(32'h0000001f, 32'h0000ffff, 4'b0010);
    check("lat_e2_res_valid", 64'(res_valid), 64'd1);
    check("lat_e2_res_r", 64'(res_r), 64'(m[35:4]));
    check("lat_e2_res_flags", 64'(res_flags), 64'(m[3:0]));
    check("lat_e2_res_tag", 64'(res_tag), 64'd0);
    wait_idle(20);

    // Table vectors against hand-derived results
    do_reset();
    got_q.delete();
    for (int i = 0; i < 11; i++) push(tbl[i].a, tbl[i].b, tbl[i].op);
    wait_idle(100);
    check("tbl_count", 64'(got_q.size()), 64'd11);
    for (int i = 0; i < 11 && i < got_q.size(); i++) begin
      check($sformatf("tbl%0d_r", i), 64'(got_q[i][39:8]), 64'(tbl[i].r));
      check($sformatf("tbl%0d_flags", i), 64'(got_q[i][7:4]), 64'(tbl[i].flags));
      check($sformatf("tbl%0d_tag", i), 64'(got_q[i][3:0]), 64'(i));
    end

    // Burst of all 16 opcodes, then a 17th that wraps the tag
    do_reset();
    got_q.delete();
    pop_cyc.delete();
    for (int op = 0; op < 16; op++) push(32'h0000001f, 32'h0000ffff, 4'(op));
    wait_idle(100);
    check("burst_count", 64'(got_q.size()), 64'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      check($sformatf("burst%0d_tag", i), 64'(got_q[i][3:0]), 64'(i));
    for (int i = 1; i < 16 && i < pop_cyc.size(); i++)
      check($sformatf("burst%0d_rate", i), 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);
    push(32'h0000001f, 32'h0000ffff, 4'd0);
    wait_idle(20);
    check("tag_wrap_count", 64'(got_q.size()), 64'd17);
    if (got_q.size() == 17) check("tag_wrap", 64'(got_q[16][3:0]), 64'd0);

    // Backpressure: 4 results captured, 4 commands buffered, then drain
    do_reset();
    got_q.delete();
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h1000 + 32'(i), 32'(i * 3), 4'(i));
    tick(); tick(); tick();
    check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    check("bp_res_valid", 64'(res_valid), 64'd1);
    check("bp_last_issued", 64'(alu_a), 64'h1003);
    check("bp_head_tag", 64'(res_tag), 64'd0);
    // Offer a push into the full command FIFO on the same edge as the first result pop
    cmd_a = 32'h1008; cmd_b = 32'(8 * 3); cmd_aluc = 4'd8; cmd_valid = 1'b1;
    res_ready = 1'b1;
    tick();
    check("simul_cmd_ready", 64'(cmd_ready), 64'd0);
    check("simul_head_tag", 64'(res_tag), 64'd1);
    check("simul_popped", 64'(got_q.size()), 64'd1);
    push(32'h1008, 32'(8 * 3), 4'd8);
    push(32'h1009, 32'(9 * 3), 4'd9);
    wait_idle(200);
    check("bp_count", 64'(got_q.size()), 64'd10);
    for (int i = 0; i < 10 && i < got_q.size(); i++)
      check($sformatf("bp%0d", i), 64'(got_q[i]), 64'({alu_f(32'h1000 + 32'(i), 32'(i * 3), 4'(i)), 4'(i)}));

    // Reset while the first of two queued commands is on the ALU
    do_reset();
    got_q.delete();
    res_ready = 1'b1;
    cmd_a = 32'h11; cmd_b = 32'h22; cmd_aluc = 4'd0; cmd_valid = 1'b1;
    tick();
    cmd_a = 32'h33; cmd_b = 32'h44; cmd_aluc = 4'd1;
    tick();
    check("mid_alu_a", 64'(alu_a), 64'h11);
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (6) tick();
    check("midrst_no_result", 64'(got_q.size()), 64'd0);
    push(32'habc, 32'h123, 4'd0);
    wait_idle(20);
    check("midrst_next_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) check("midrst_next_tag", 64'(got_q[0][3:0]), 64'd0);

    // ALU_LAT=3 instance: each operand set held for three cycles
    res_ready3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_a3 = 32'd100 + 32'(i); cmd_b3 = 32'(i * 7); cmd_aluc3 = 4'(i); cmd_valid3 = 1'b1;
      k = 0;
      while (!cmd_ready3 && k < 50) begin tick(); k++; end
      if (!cmd_ready3) bound_fail("lat3_push_wait");
      tick();
      cmd_valid3 = 1'b0;
    end
    k = 0;
    while (busy3 && k < 100) begin tick(); k++; end
    if (busy3) bound_fail("lat3_wait_idle");
    for (int i = 0; i < 3; i++) check($sformatf("lat3_hold%0d", i), 64'(hold_n[i]), 64'd3);
    check("lat3_hold3_min", 64'(hold_n[3] >= 3), 64'd1);
    check("lat3_count", 64'(got3_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < got3_q.size(); i++)
      check($sformatf("lat3_res%0d", i), 64'(got3_q[i]), 64'({alu_f(32'd100 + 32'(i), 32'(i * 7), 4'(i)), 4'(i)}));

    // Randomised traffic against the scoreboard
    do_reset();
    got_q.delete();
    for (int c = 0; c < 400; c++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a     = $urandom;
      cmd_b     = ($urandom_range(0, 3) == 0) ? cmd_a : $urandom;
      cmd_aluc  = 4'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle(200);
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
